// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline-register taps in, stall/flush/forward selects out |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface hazard_ctrl_if;
  logic [4:0]  rs1_d, rs2_d;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [1:0]  res_src_e;
  logic        pc_src_e;
  logic [4:0]  rd_m, rd_w;
  logic        reg_wr_m, reg_wr_w;
  logic        mem_req_m, mem_ack;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [15:0] stall_cnt;
  logic        err_timeout;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
           rd_m, rd_w, reg_wr_m, reg_wr_w, mem_req_m, mem_ack,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, stall_cnt, err_timeout
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
           rd_m, rd_w, reg_wr_m, reg_wr_w, mem_req_m, mem_ack,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, stall_cnt, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl : 5-stage pipe sequencer (boot bubbles, load-use, branch,       |
// |               data-memory wait) plus EX-stage forwarding selects            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  wire logic      clk,
  input  wire logic      rst,
  hazard_ctrl_if.slave   bus
);

  localparam logic [3:0]  C_BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [15:0] C_TIMEOUT   = 16'(MEM_TIMEOUT);
  localparam logic [15:0] C_CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        err_q, err_d;

  logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic w_flush_d, w_flush_e, w_flush_w;
  logic w_lw_hz, w_mem_wait;

  assign w_lw_hz = (bus.res_src_e == 2'b01) && (bus.rd_e != 5'd0) &&
                   ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));
  assign w_mem_wait = bus.mem_req_m && !bus.mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= 4'd0;
      wait_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    w_stall_f  = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_e  = 1'b0;
    w_stall_m  = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    w_flush_w  = 1'b0;

    case (state_q)
      S_BOOT: begin
        w_stall_f = 1'b1;
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
        if (boot_cnt_q >= C_BOOT_LAST) begin
          state_d    = S_RUN;
          boot_cnt_d = 4'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      // RUN and MEM_WAIT share one decode: the wait is decided combinationally
      // from mem_req_m/mem_ack, the registered state only records it.
      S_RUN, S_WAIT: begin
        if (w_mem_wait) begin
          w_stall_f  = 1'b1;
          w_stall_d  = 1'b1;
          w_stall_e  = 1'b1;
          w_stall_m  = 1'b1;
          w_flush_w  = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = (wait_cnt_q >= C_TIMEOUT) ? wait_cnt_q : wait_cnt_q + 16'd1;
          if (wait_cnt_d >= C_TIMEOUT) begin
            err_d = 1'b1;
          end
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = 16'd0;
          if (bus.pc_src_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_lw_hz) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_BOOT;
        boot_cnt_d = 4'd0;
        wait_cnt_d = 16'd0;
      end
    endcase

    stall_cnt_d = (w_stall_f && (stall_cnt_q != C_CNT_MAX)) ? stall_cnt_q + 16'd1
                                                             : stall_cnt_q;
  end

  function automatic logic [1:0] fwd_sel(
    input logic       in_rst,
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    if (in_rst)                                 return 2'b00;
    else if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                        return 2'b00;
  endfunction

  assign bus.fwd_a_e = fwd_sel(rst, bus.rs1_e, bus.reg_wr_m, bus.rd_m, bus.reg_wr_w, bus.rd_w);
  assign bus.fwd_b_e = fwd_sel(rst, bus.rs2_e, bus.reg_wr_m, bus.rd_m, bus.reg_wr_w, bus.rd_w);

  assign bus.stall_f     = w_stall_f;
  assign bus.stall_d     = w_stall_d;
  assign bus.stall_e     = w_stall_e;
  assign bus.stall_m     = w_stall_m;
  assign bus.flush_d     = w_flush_d;
  assign bus.flush_e     = w_flush_e;
  assign bus.flush_w     = w_flush_w;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.err_timeout = err_q;

endmodule
`default_nettype wire
